// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer wrap, count width and flag decode.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit wrap so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic fifo_flags_t calc_flags(input int unsigned cnt, input int unsigned depth,
                                               input int unsigned af_lvl, input int unsigned ae_lvl);
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 0);
        f.almost_full  = (cnt >= af_lvl);
        f.almost_empty = (cnt <= ae_lvl);
        return f;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
module fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Only the output register is cleared; the array keeps its contents.
    always_ff @(posedge clk) begin
        if (clr)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with exact count, threshold flags and access error pulses.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3,
    parameter int AE_LVL = 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = addr_width(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_sync_param: DEPTH must be >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_param: AF_LVL out of range");
    end
    if (AE_LVL < 0 || AE_LVL >= DEPTH) begin : g_bad_ae
        $fatal(1, "fifo_sync_param: AE_LVL out of range");
    end

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             rd_acc, wr_acc;
    logic [CNT_W-1:0] count_nxt;
    fifo_flags_t      flags_nxt;

    always_comb begin
        rd_acc    = rd_en & ~empty;
        wr_acc    = wr_en & (~full | rd_acc);
        count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        flags_nxt = calc_flags(32'(count_nxt), DEPTH, AF_LVL, AE_LVL);
    end

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .clr     (reset),
        .wr_en   (wr_acc & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (rd_acc)
                rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
            count        <= count_nxt;
            rd_valid     <= rd_acc;
            full         <= flags_nxt.full;
            empty        <= flags_nxt.empty;
            almost_full  <= flags_nxt.almost_full;
            almost_empty <= flags_nxt.almost_empty;
            overflow     <= wr_en & ~wr_acc;
            underflow    <= rd_en & ~rd_acc;
        end
    end

endmodule
